reg_trace_tx: RTL and testbench
===============================

Name: reg_trace_tx

Overview:
- Hardware transmitter for processor test results: produces the register write-back trace and end-of-run register dump as a ready/valid record stream, for an off-chip or bench-side checker to compare against expected values.
- Sits between the processor, regfile and the checker link.
- Snoops write-back during a run of N cycles, then takes over regfile read port A and dumps r0..r31.

Parameters:
- CYCLE_W, 10, width of the cycle counter and run length.
- NREGS, 32, registers dumped; index width is 5.
- FIFO_DEPTH, 4, trace record buffer entries; power of two.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; ignored unless state is IDLE or DONE.
- run_cycles  in  CYCLE_W  number of cycles to trace; sampled at start.
- rwe  in  1  regfile write enable snooped from the processor.
- rd  in  5  regfile write index snooped.
- rdata  in  32  regfile write data snooped.
- rs1_proc  in  5  processor read port A index.
- rs1_out  out  5  read port A index driven to the regfile.
- regA  in  32  regfile read port A data (combinational read).
- out_valid  out  1  record valid.
- out_ready  in  1  consumer accepts the record.
- out_kind  out  1  record type: 0 = write record, 1 = dump record.
- out_cycle  out  CYCLE_W  cycle index for write records; 0 for dump records.
- out_reg  out  5  register index.
- out_data  out  32  value.
- busy  out  1  high in every state other than IDLE and DONE.
- done  out  1  high in DONE.
- overflow  out  1  sticky; set when a trace record is dropped.

Behaviour:
- Reset values: state IDLE; out_valid, busy, done and overflow 0; all counters, FIFO pointers and out_* fields 0.
- rs1_out equals rs1_proc in every state except DUMP_ADDR, DUMP_SETTLE and DUMP_SEND, where it equals dump_idx.
- Handshake: a record transfers on a rising edge with out_valid && out_ready. While out_valid && !out_ready, all out_* fields hold stable. out_valid does not drop until the record is accepted.
- IDLE/DONE, start=1: latch run_cycles, clear cyc and overflow, drop done.
  - run_cycles == 0: go to DRAIN.
  - otherwise: go to RUN.
- RUN:
  - On each edge where rwe && rd != 0, push {cyc, rd, rdata} into the FIFO.
  - If the FIFO is full and no pop happens on the same edge, drop the record and set overflow. A simultaneous push and pop when full is legal.
  - cyc increments every edge. On the edge where cyc == run_cycles-1, take the final sample, then go to DRAIN.
- FIFO head drives the output in RUN and DRAIN, with out_kind = 0.
- DRAIN: when the FIFO is empty and no record is pending, set dump_idx = 0 and go to DUMP_ADDR.
- DUMP_ADDR: present the index for one cycle, then go to DUMP_SETTLE.
- DUMP_SETTLE: capture regA into the output register; out_kind = 1, out_reg = dump_idx, out_cycle = 0; assert out_valid; go to DUMP_SEND.
- DUMP_SEND: on accept:
  - dump_idx == NREGS-1: go to DONE.
  - otherwise: dump_idx+1 and return to DUMP_ADDR.
- Each dump record takes at least 3 cycles.
- DONE: done = 1 and out_valid = 0 until the next start.
- start while busy has no effect.
- Reset asserted mid-run returns to the reset values immediately. No partial record completes.
- Counter width: cyc wraps modulo 2^CYCLE_W. The maximum run is 2^CYCLE_W - 1 cycles.

Decomposition:
- Shared package reg_trace_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DUMP_ADDR, DUMP_SETTLE, DUMP_SEND, DONE};
  - KIND_WRITE=0 and KIND_DUMP=1;
  - the trace record struct {cycle, reg, data}.
- One sub-module, reg_trace_fifo: synchronous FIFO with full/empty flags, same clock and reset.

Test Plan:
- run_cycles=8; rwe=1 rd=5 rdata=42 at cycle 3; out_ready=1 -> exactly one write record {kind 0, cycle 3, reg 5, data 42}, then 32 dump records, then done=1.
- run_cycles=8; writes to rd=0 at cycles 1 and 2 -> no write records emitted.
- out_ready=0 for 20 cycles during a run with writes at cycles 0..5 and FIFO_DEPTH=4 -> 4 records retained, overflow=1, head record fields stable until ready rises.
- Regfile preloaded with r7=-1 and r31=0x12345678 -> dump records carry reg 7 data 0xFFFFFFFF and reg 31 data 0x12345678. rs1_out follows rs1_proc outside the DUMP states.
- Reset pulled low during DUMP_SEND with dump_idx=10 -> next cycle out_valid=0, busy=0 and state IDLE. A new start gives a full run and dump.
- run_cycles=0, start -> no write records, 32 dump records, done=1. A start pulse while busy changes nothing.

Source files
------------

// File: rtl/reg_trace_pkg.sv
// rtl/reg_trace_pkg.sv - shared types and constants for the register trace transmitter
// Purpose: state encoding, record kinds, widths and the trace record layout
//          used by reg_trace_tx and reg_trace_fifo.
// Ports:   none (package).
package reg_trace_pkg;

  localparam int CYCLE_W        = 10;
  localparam int NREGS          = 32;
  localparam int IDX_W          = 5;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic KIND_WRITE = 1'b0;
  localparam logic KIND_DUMP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DUMP_ADDR,
    DUMP_SETTLE,
    DUMP_SEND,
    DONE
  } state_t;

  typedef struct packed {
    logic [CYCLE_W-1:0] cycle;
    logic [IDX_W-1:0]   regn;
    logic [31:0]        data;
  } trace_rec_t;

endpackage

// File: rtl/reg_trace_fifo.sv
// rtl/reg_trace_fifo.sv - synchronous trace record FIFO with full/empty flags
// Purpose: buffers write-back trace records; the head entry is visible on
//          o_head whenever o_empty is low.
// Ports:   clock, reset (async active-low)
//          i_push/i_rec  write a record (ignored when full unless popping)
//          i_pop         remove the head record (ignored when empty)
//          o_head        current head record
//          o_full/o_empty occupancy flags
import reg_trace_pkg::*;

module reg_trace_fifo #(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  trace_rec_t i_rec,
  input  logic       i_pop,
  output trace_rec_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t     r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_do_pop;
  logic           w_do_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_head  = r_mem[r_rptr];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_rec;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

endmodule

// File: rtl/reg_trace_tx.sv
// rtl/reg_trace_tx.sv - write-back trace and register dump record transmitter
// Purpose: snoops regfile write-back for run_cycles cycles, streams the trace
//          from a small FIFO, then borrows read port A to dump r0..r31.
// Ports:   clock, reset (async active-low); start/run_cycles begin a run
//          rwe/rd/rdata   snooped write-back
//          rs1_proc/rs1_out/regA  read port A pass-through / dump access
//          out_valid/out_ready/out_kind/out_cycle/out_reg/out_data  record stream
//          busy, done, overflow (sticky dropped-record flag)
import reg_trace_pkg::*;

module reg_trace_tx #(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYCLE_W-1:0] run_cycles,
  input  logic               rwe,
  input  logic [4:0]         rd,
  input  logic [31:0]        rdata,
  input  logic [4:0]         rs1_proc,
  output logic [4:0]         rs1_out,
  input  logic [31:0]        regA,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_kind,
  output logic [CYCLE_W-1:0] out_cycle,
  output logic [4:0]         out_reg,
  output logic [31:0]        out_data,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  state_t             r_state;
  state_t             w_next;
  logic [CYCLE_W-1:0] r_run_len;
  logic [CYCLE_W-1:0] r_cyc;
  logic [4:0]         r_dump_idx;
  logic               r_dump_valid;
  logic [31:0]        r_dump_data;
  logic               r_overflow;

  trace_rec_t w_in_rec;
  trace_rec_t w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_stream;
  logic       w_dumping;
  logic       w_idle;
  logic       w_start;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic       w_last;
  logic       w_dump_accept;

  assign w_idle        = (r_state == IDLE) || (r_state == DONE);
  assign w_stream      = (r_state == RUN) || (r_state == DRAIN);
  assign w_dumping     = (r_state == DUMP_ADDR) || (r_state == DUMP_SETTLE) ||
                         (r_state == DUMP_SEND);
  assign w_start       = start && w_idle;
  assign w_push        = (r_state == RUN) && rwe && (rd != '0);
  assign w_pop         = w_stream && !w_empty && out_ready;
  assign w_drop        = w_push && w_full && !w_pop;
  assign w_last        = (r_cyc == r_run_len - CYCLE_W'(1));
  assign w_dump_accept = (r_state == DUMP_SEND) && r_dump_valid && out_ready;
  assign w_in_rec      = {r_cyc, rd, rdata};

  reg_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_rec   (w_in_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next = (run_cycles == '0) ? DRAIN : RUN;
        end
      end
      RUN:         if (w_last) w_next = DRAIN;
      // The FIFO head is the pending record, so empty means nothing in flight.
      DRAIN:       if (w_empty) w_next = DUMP_ADDR;
      DUMP_ADDR:   w_next = DUMP_SETTLE;
      DUMP_SETTLE: w_next = DUMP_SEND;
      DUMP_SEND: begin
        if (w_dump_accept) begin
          w_next = (r_dump_idx == 5'(NREGS-1)) ? DONE : DUMP_ADDR;
        end
      end
      default:     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_run_len    <= '0;
      r_cyc        <= '0;
      r_dump_idx   <= '0;
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_start) begin
        r_run_len  <= run_cycles;
        r_cyc      <= '0;
        r_overflow <= 1'b0;
      end
      if (r_state == RUN) begin
        r_cyc <= r_cyc + CYCLE_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (r_state == DRAIN) begin
        r_dump_idx <= '0;
      end
      // regA is a combinational read of rs1_out, which has held dump_idx since DUMP_ADDR.
      if (r_state == DUMP_SETTLE) begin
        r_dump_valid <= 1'b1;
        r_dump_data  <= regA;
      end
      if (w_dump_accept) begin
        r_dump_valid <= 1'b0;
        if (r_dump_idx != 5'(NREGS-1)) begin
          r_dump_idx <= r_dump_idx + 5'd1;
        end
      end
    end
  end

  assign rs1_out   = w_dumping ? r_dump_idx : rs1_proc;
  assign out_valid = w_stream ? !w_empty : r_dump_valid;
  assign out_kind  = w_stream ? KIND_WRITE : (r_dump_valid ? KIND_DUMP : KIND_WRITE);
  assign out_cycle = w_stream ? w_head.cycle : '0;
  assign out_reg   = w_stream ? w_head.regn : r_dump_idx;
  assign out_data  = w_stream ? w_head.data : r_dump_data;
  assign busy      = !w_idle;
  assign done      = (r_state == DONE);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_reg_trace_tx.sv
// tb/tb_reg_trace_tx.sv - self-checking bench for reg_trace_tx
module tb_reg_trace_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  run_cycles = '0;
  logic        rwe = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] rdata = '0;
  logic [4:0]  rs1_proc = '0;
  logic [4:0]  rs1_out;
  logic [31:0] regA;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_kind;
  logic [9:0]  out_cycle;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] regs [32];
  logic [47:0] exp_q [$];

  typedef struct {
    int          run;
    int          cyc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        exp;
  } wvec_t;
  wvec_t tbl [$];

  assign regA = regs[rs1_out];

  always #5 clock = ~clock;

  reg_trace_tx dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .run_cycles (run_cycles),
    .rwe        (rwe),
    .rd         (rd),
    .rdata      (rdata),
    .rs1_proc   (rs1_proc),
    .rs1_out    (rs1_out),
    .regA       (regA),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kind   (out_kind),
    .out_cycle  (out_cycle),
    .out_reg    (out_reg),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard side: records are compared as they transfer; stalled records must hold.
  logic        hold_v = 1'b0;
  logic [47:0] hold_rec;
  always @(negedge clock) begin
    if (!reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("valid_held", 64'(out_valid), 64'd1);
        if (out_valid) check("fields_held", 64'({out_kind, out_cycle, out_reg, out_data}), 64'(hold_rec));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_record", 64'({out_kind, out_cycle, out_reg, out_data}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("record", 64'({out_kind, out_cycle, out_reg, out_data}), 64'(exp_q.pop_front()));
        end
        if (out_kind) check("rs1_dump_idx", 64'(rs1_out), 64'(out_reg));
        hold_v = 1'b0;
      end else if (out_valid) begin
        hold_v   = 1'b1;
        hold_rec = {out_kind, out_cycle, out_reg, out_data};
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic check_idle(input string name);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_ovf"}, 64'(overflow), 64'd0);
    check({name, "_fields"}, 64'({out_kind, out_cycle, out_reg, out_data}), 64'd0);
    check({name, "_rs1"}, 64'(rs1_out), 64'(rs1_proc));
  endtask

  // One run: trace phase from the vector table, then dump; abort_idx >= 0 resets mid-dump.
  task automatic do_run(input int run_id, input int len, input int hold,
                        input logic exp_ovf, input logic busy_start, input int abort_idx);
    int  k;
    int  ndump;
    logic found;
    k = 0;
    found = 1'b0;
    rs1_proc   = 5'($urandom);
    run_cycles = 10'(len);
    out_ready  = (hold == 0);
    start      = 1'b1;
    tick();
    start = 1'b0;
    k++;
    for (int c = 0; c < len; c++) begin
      logic        we_now;
      logic [4:0]  rd_now;
      logic [31:0] d_now;
      we_now = 1'b0;
      rd_now = '0;
      d_now  = '0;
      foreach (tbl[i]) begin
        if (tbl[i].run == run_id && tbl[i].cyc == c) begin
          we_now = tbl[i].we;
          rd_now = tbl[i].rd;
          d_now  = tbl[i].d;
          if (tbl[i].exp) exp_q.push_back({1'b0, 10'(c), tbl[i].rd, tbl[i].d});
        end
      end
      rwe       = we_now;
      rd        = rd_now;
      rdata     = d_now;
      rs1_proc  = 5'($urandom);
      out_ready = (k >= hold);
      #1;
      check("rs1_pass_run", 64'(rs1_out), 64'(rs1_proc));
      tick();
      k++;
      if (we_now && rd_now != '0) regs[rd_now] = d_now;
    end
    rwe = 1'b0;
    rd  = '0;
    ndump = (abort_idx >= 0) ? abort_idx : 32;
    for (int r = 0; r < ndump; r++) exp_q.push_back({1'b1, 10'd0, 5'(r), regs[r]});
    for (int t = 0; t < 600 && !done; t++) begin
      if (abort_idx >= 0 && out_valid && out_kind && out_reg == 5'(abort_idx)) begin
        found = 1'b1;
        break;
      end
      out_ready = (k >= hold);
      rs1_proc  = 5'($urandom);
      if (busy_start && t == 5) begin
        start      = 1'b1;
        run_cycles = 10'd3;
      end else begin
        start = 1'b0;
      end
      if (busy_start && t == 6) check("busy_start_ignored", 64'(busy), 64'd1);
      tick();
      k++;
    end
    start = 1'b0;
    if (abort_idx >= 0) begin
      check("reached_abort_idx", 64'(found), 64'd1);
      out_ready = 1'b0;
      reset     = 1'b0;
      #1;
      check("reset_now_valid", 64'(out_valid), 64'd0);
      check("reset_now_busy", 64'(busy), 64'd0);
      tick();
      check_idle("reset_next");
      check("reset_queue_empty", 64'(exp_q.size()), 64'd0);
      reset     = 1'b1;
      out_ready = 1'b1;
      tick();
    end else begin
      check("done_reached", 64'(done), 64'd1);
      check("done_valid_low", 64'(out_valid), 64'd0);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("overflow_flag", 64'(overflow), 64'(exp_ovf));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h0101_0101 * i;
    regs[7]  = 32'hFFFF_FFFF;
    regs[31] = 32'h1234_5678;

    tbl.push_back('{0, 3, 1'b1, 5'd5, 32'd42, 1'b1});
    tbl.push_back('{1, 1, 1'b1, 5'd0, 32'h11, 1'b0});
    tbl.push_back('{1, 2, 1'b1, 5'd0, 32'h22, 1'b0});
    tbl.push_back('{1, 5, 1'b0, 5'd9, 32'h99, 1'b0});
    for (int c = 0; c < 6; c++) tbl.push_back('{2, c, 1'b1, 5'(c + 1), 32'hA0 + c, (c < 4)});
    tbl.push_back('{4, 0, 1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1});
    tbl.push_back('{4, 3, 1'b1, 5'd7, 32'h0000_0077, 1'b1});

    rs1_proc = 5'd13;
    #12;
    check_idle("reset");
    reset = 1'b1;
    tick();
    check_idle("after_reset");

    do_run(0, 8, 0, 1'b0, 1'b0, -1);
    do_run(1, 8, 0, 1'b0, 1'b0, -1);
    do_run(2, 8, 20, 1'b1, 1'b0, -1);
    do_run(3, 0, 0, 1'b0, 1'b1, -1);
    do_run(5, 2, 0, 1'b0, 1'b0, 10);
    do_run(4, 4, 0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
